// File: rtl/issue_scoreboard_pkg.sv
// Shared definitions for the issue scoreboard.
// Contents: the issue FSM state type, register-file constants and the default
// sizing for the pending-write counters and the in-flight window.
package issue_scoreboard_pkg;

    typedef enum logic {
        StRun    = 1'b0,
        StSerial = 1'b1
    } state_e;

    localparam int unsigned NUM_REGS = 32;
    localparam logic [4:0]  REG_X0   = 5'd0;

    localparam int unsigned DEF_CNT_W        = 2;
    localparam int unsigned DEF_MAX_INFLIGHT = 4;
    localparam int unsigned DEF_INFL_W       = 3;

endpackage

// File: rtl/issue_scoreboard_pending_counter.sv
// Per-register pending-write counter.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   inc        a write to this register issues this cycle
//   dec        a write to this register retires this cycle
//   count      current number of outstanding writes
//   nonzero    count != 0
//   at_max     count == 2^CNT_W-1
module issue_scoreboard_pending_counter #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] MaxVal = '1;

    logic [CNT_W-1:0] count_q, count_d;

    // Simultaneous inc and dec cancel. A decrement at zero is a protocol
    // error and is floored; an increment at max cannot happen because issue
    // stalls on saturation, but is held anyway rather than wrapping.
    always_comb begin
        count_d = count_q;
        if (inc && !dec) begin
            if (count_q != MaxVal) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count   = count_q;
    assign nonzero = (count_q != '0);
    assign at_max  = (count_q == MaxVal);

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller.
// Tracks outstanding register writes (one counter per x1..x31) and the number
// of in-flight instructions, and decides each cycle whether the decoded
// instruction may advance into ID/EX.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     decoded instruction (valid, sources, dest, serialize)
//   ex_ready                 ID/EX can accept
//   flush                    kill the instruction currently in ID
//   wb_valid/wb_rf_wen/wb_rd retirement of one instruction
//   issue_fire               instruction advances this cycle (combinational)
//   stall_raw/struct/serial  stall reasons
//   busy_mask                bit r set while writes to r are pending
//   inflight_cnt             instructions issued but not yet retired
module issue_scoreboard
    import issue_scoreboard_pkg::*;
#(
    parameter int unsigned CNT_W        = DEF_CNT_W,
    parameter int unsigned MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int unsigned INFL_W       = DEF_INFL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_reg_wen,
    input  logic              id_serialize,
    input  logic              ex_ready,
    input  logic              flush,
    input  logic              wb_valid,
    input  logic              wb_rf_wen,
    input  logic [4:0]        wb_rd,
    output logic              issue_fire,
    output logic              stall_raw,
    output logic              stall_struct,
    output logic              stall_serial,
    output logic [31:0]       busy_mask,
    output logic [INFL_W-1:0] inflight_cnt
);

    state_e            state_q, state_d;
    logic [INFL_W-1:0] inflight_q, inflight_d;

    logic [NUM_REGS-1:1] rel, inc;
    logic [NUM_REGS-1:0] nonzero, at_max, is_one;

    logic rel_rs1, rel_rs2, rel_rd;
    logic raw_rs1, raw_rs2, sat, full, drained;
    logic wb_dec;

    // x0 is never tracked.
    assign nonzero[0] = 1'b0;
    assign at_max[0]  = 1'b0;
    assign is_one[0]  = 1'b0;

    always_comb begin
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            rel[r] = wb_valid && wb_rf_wen && (wb_rd == 5'(r));
            inc[r] = issue_fire && id_reg_wen && (id_rd == 5'(r));
        end
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        logic [CNT_W-1:0] count;

        issue_scoreboard_pending_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[r]),
            .dec     (rel[r]),
            .count   (count),
            .nonzero (nonzero[r]),
            .at_max  (at_max[r])
        );

        assign is_one[r] = (count == CNT_W'(1));
    end

    // Hazard and stall decode.
    always_comb begin
        rel_rs1 = wb_valid && wb_rf_wen && (wb_rd == id_rs1) && (id_rs1 != REG_X0);
        rel_rs2 = wb_valid && wb_rf_wen && (wb_rd == id_rs2) && (id_rs2 != REG_X0);
        rel_rd  = wb_valid && wb_rf_wen && (wb_rd == id_rd)  && (id_rd  != REG_X0);

        // The last pending write retiring this cycle is covered by the
        // decoder's writeback bypass.
        raw_rs1 = id_uses_rs1 && (id_rs1 != REG_X0) && nonzero[id_rs1] &&
                  !(is_one[id_rs1] && rel_rs1);
        raw_rs2 = id_uses_rs2 && (id_rs2 != REG_X0) && nonzero[id_rs2] &&
                  !(is_one[id_rs2] && rel_rs2);

        sat     = id_reg_wen && (id_rd != REG_X0) && at_max[id_rd] && !rel_rd;
        full    = (inflight_q == INFL_W'(MAX_INFLIGHT)) && !wb_valid;
        drained = (inflight_q == '0) || ((inflight_q == INFL_W'(1)) && wb_valid);

        stall_raw    = !rst && id_valid && (raw_rs1 || raw_rs2);
        stall_struct = !rst && id_valid && (sat || full);
        stall_serial = !rst && id_valid &&
                       ((state_q == StSerial) || (id_serialize && !drained));

        issue_fire = id_valid && !flush && ex_ready && !stall_raw && !stall_struct &&
                     !stall_serial && !rst;
    end

    // In-flight window; a retirement with nothing in flight is ignored.
    always_comb begin
        wb_dec     = wb_valid && (inflight_q != '0);
        inflight_d = inflight_q;
        if (issue_fire && !wb_dec) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (!issue_fire && wb_dec) begin
            inflight_d = inflight_q - INFL_W'(1);
        end
    end

    // SERIAL holds until the serializing instruction, the only one left in
    // flight, retires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun: begin
                if (issue_fire && id_serialize) begin
                    state_d = StSerial;
                end
            end
            StSerial: begin
                if (wb_valid && (inflight_q == INFL_W'(1))) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StRun;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

    assign busy_mask    = nonzero;
    assign inflight_cnt = inflight_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue controller for the decode stage; sits between the decoder outputs and the ID/EX stage register.
- Tracks outstanding register writes with per-register pending counters and tracks total in-flight instructions.
- Decides each cycle whether the decoded instruction may advance. It stalls on RAW hazards that the same-cycle writeback bypass cannot cover, on pending-counter saturation, on in-flight capacity, and on serialization for FENCE/SYSTEM/CSR.

Parameters:
- CNT_W, 2: width of each per-register pending-write counter; max value 2^CNT_W-1.
- MAX_INFLIGHT, 4: maximum instructions issued but not yet retired.
- INFL_W, 3: width of the in-flight counter; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decoded instruction present (decoder out_valid)
- id_rs1  in  5  source register 1
- id_rs2  in  5  source register 2
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2
- id_rd  in  5  destination register
- id_reg_wen  in  1  instruction writes rd
- id_serialize  in  1  FENCE/FENCE.I, SYSTEM or CSR instruction
- ex_ready  in  1  ID/EX register can accept
- flush  in  1  kill the instruction currently in ID
- wb_valid  in  1  one instruction retires this cycle (every instruction retires exactly once)
- wb_rf_wen  in  1  the retiring instruction writes the register file
- wb_rd  in  5  register written by the retiring instruction
- issue_fire  out  1  instruction advances into ID/EX this cycle
- stall_raw  out  1  blocked by a RAW hazard
- stall_struct  out  1  blocked by counter saturation or full in-flight window
- stall_serial  out  1  blocked by serialization (drain or SERIAL state)
- busy_mask  out  32  bit r = 1 when the pending counter for r is nonzero; bit 0 is always 0
- inflight_cnt  out  INFL_W  instructions currently in flight

Behaviour:
- Reset (sync, rst=1 at a clk edge): all pending counters = 0, inflight_cnt = 0, FSM = RUN. busy_mask = 0. All stall outputs and issue_fire are 0 while rst is high.
- Release: rel(r) = wb_valid & wb_rf_wen & (wb_rd==r) & (r!=0).
- RAW for source s: uses_s & s!=0 & cnt[s]!=0 & !(cnt[s]==1 & rel(s)).
  - A retirement in the same cycle that clears the last pending write is covered by the decoder's writeback bypass, so it does not stall.
- stall_raw = id_valid & (RAW(rs1) | RAW(rs2)).
- stall_struct = id_valid & (sat | full), where:
  - sat = id_reg_wen & id_rd!=0 & cnt[id_rd]==max & !rel(id_rd)
  - full = inflight_cnt==MAX_INFLIGHT & !wb_valid
- stall_serial = id_valid & (state==SERIAL | (id_serialize & !drained)), where drained = inflight_cnt==0 | (inflight_cnt==1 & wb_valid).
- issue_fire = id_valid & !flush & ex_ready & !stall_raw & !stall_struct & !stall_serial & !rst. Purely combinational; zero-cycle latency.
- flush: suppresses issue_fire in that cycle only; does not change counters or FSM.
  - Instructions already in flight are older than the flushing branch and still retire normally.
- Counter update at each clk edge:
  - cnt[r] += (issue_fire & id_reg_wen & id_rd==r & r!=0) − rel(r).
  - An increment and a decrement on the same r in the same cycle leave cnt[r] unchanged.
  - The decrement saturates at 0 (protocol error; the bench flags it).
  - x0 is never tracked.
- inflight_cnt update: += issue_fire − wb_valid. The decrement is ignored when the count is 0 (protocol error).
- FSM:
  - RUN -> SERIAL on issue_fire & id_serialize.
  - SERIAL -> RUN when wb_valid & inflight_cnt==1 (the serializing instruction retires).
  - No issue while in SERIAL.
  - A serializing instruction that retires in the same cycle it issues is impossible (at least 1 cycle in EX).
- Reset mid-operation: all state is discarded; the next cycle is RUN with empty counters.

Decomposition:
- Shared package:
  - FSM state enum {RUN, SERIAL}
  - NUM_REGS = 32
  - REG_X0 = 5'd0
  - default CNT_W / MAX_INFLIGHT constants
- Sub-module pending_counter: CNT_W-bit up/down counter with inc, dec, the simultaneous inc+dec hold rule, and zero floor. Outputs: count, nonzero, at_max. Instantiated for registers 1..31 via generate.

Test Plan:
- RAW: issue rd=5 (cnt[5]=1); next cycle instruction with rs1=5 and no wb -> stall_raw=1, issue_fire=0. When wb_valid=1, wb_rd=5 in a cycle -> issue_fire=1 that same cycle, and busy_mask[5]=0 after the edge.
- WAW saturation (CNT_W=2): issue 3 writes to rd=7 without retirement -> cnt[7]=3. A 4th write to rd=7 -> stall_struct=1. On the cycle with wb_rd=7, wb_valid=1 -> issue_fire=1 and cnt stays 3.
- Window full: issue 4 instructions with rd=0 and no retirement -> inflight_cnt=4, 5th stalls (stall_struct=1). A simultaneous wb_valid -> 5th issues and inflight_cnt stays 4.
- Serialization: with inflight_cnt=2, present a FENCE -> stall_serial=1 until drained. After it issues, state=SERIAL and a following ADD stalls until the FENCE retires -> RUN, then the ADD issues.
- Flush and x0: flush=1 with a valid, hazard-free instruction -> issue_fire=0 and counters unchanged. An instruction with rd=0 and reg_wen=1 -> busy_mask stays 0; rs1=0 never stalls.
- Reset mid-run: cnt[3]=2, inflight=3, state=SERIAL; assert rst for one cycle -> busy_mask=0, inflight_cnt=0, state RUN. The next valid instruction issues immediately.
